// File: rtl/cam_pkg.sv
// Shared widths, FSM state type and address helper for the camera frame writer.
package cam_pkg;
    localparam int PIX_W     = 8;
    localparam int COORD_W   = 10;
    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Byte address of the 32-bit word holding pixel (x,y); wraps at 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0]        base,
                                              input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y,
                                              input int                 img_w);
        logic [31:0] lin;
        lin = 32'(y) * 32'(img_w) + 32'(x);
        return base + {lin[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/cam_frame_writer_if.sv
// Pixel stream in, packed word write bus out; master is the frame writer.
interface cam_frame_writer_if;
    import cam_pkg::*;

    logic [PIX_W-1:0]   value;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               is_val;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_wvalid;
    logic               mem_wready;

    modport master (
        input  value, x, y, is_val, mem_wready,
        output mem_addr, mem_wdata, mem_wvalid
    );

    modport slave (
        output value, x, y, is_val, mem_wready,
        input  mem_addr, mem_wdata, mem_wvalid
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/cam_frame_writer.sv
// Packs 8-bit camera pixels into 32-bit words and queues them for memory writes.
//  state      | meaning
//  ST_IDLE    | waiting for pixel (0,0) with enable high
//  ST_CAPTURE | packing pixels of the current frame
//  ST_DRAIN   | frame complete, emptying the word FIFO
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int          IMG_W      = DEF_IMG_W,
    parameter int          IMG_H      = DEF_IMG_H,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    cam_frame_writer_if.master bus,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow
);
    localparam logic [31:0] IMG_W_U = IMG_W;
    localparam logic [31:0] IMG_H_U = IMG_H;

    typedef logic [2*COORD_W-3:0] grp_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        origin;
    logic        last_pix;
    logic        start;
    logic        restart;
    logic        take;
    logic [1:0]  lane;
    grp_t        grp;
    grp_t        pack_grp;
    logic [31:0] pack;
    logic [31:0] pack_new;
    logic        push_q;
    logic [63:0] push_word;
    logic [63:0] head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign accept   = bus.is_val && (32'(bus.x) < IMG_W_U) && (32'(bus.y) < IMG_H_U);
    assign origin   = (bus.x == '0) && (bus.y == '0);
    assign last_pix = (32'(bus.x) == IMG_W_U - 32'd1) && (32'(bus.y) == IMG_H_U - 32'd1);
    assign lane     = bus.x[1:0];
    assign grp      = {bus.y, bus.x[COORD_W-1:2]};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && origin && enable) begin
                    state_nxt = ST_CAPTURE;
                    start     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    restart = origin;
                    if (last_pix) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !push_q) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign take = start || ((state == ST_CAPTURE) && accept);

    // A new word group, a frame start or a restart begins from an all-zero pack.
    always_comb begin
        pack_new = (start || restart || (grp != pack_grp)) ? 32'h0 : pack;
        pack_new[{lane, 3'b000} +: 8] = bus.value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack      <= '0;
            pack_grp  <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
        end else begin
            push_q <= 1'b0;
            if (take) begin
                pack_grp <= grp;
                if (lane == 2'd3) begin
                    push_q    <= 1'b1;
                    push_word <= {word_addr(BASE_ADDR, bus.x, bus.y, IMG_W), pack_new};
                    pack      <= '0;
                end else begin
                    pack <= pack_new;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gating with reset guarantees no handshake while queued words are discarded.
    assign bus.mem_wvalid = !fifo_empty && !reset;
    assign bus.mem_addr   = bus.mem_wvalid ? head[63:32] : 32'h0;
    assign bus.mem_wdata  = bus.mem_wvalid ? head[31:0]  : 32'h0;
    assign pop            = bus.mem_wvalid && bus.mem_wready;

    always_ff @(posedge clk) begin
        if (reset)                              overflow <= 1'b0;
        else if (start)                         overflow <= 1'b0;
        else if (push_q && fifo_full && !pop)   overflow <= 1'b1;
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed and randomized checks of cam_frame_writer against a frame-level pixel model.
module tb_cam_frame_writer;
    import cam_pkg::*;

    localparam int          W     = 8;
    localparam int          H     = 3;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;
    logic frame_done;
    logic overflow;

    cam_frame_writer_if bus_if();

    cam_frame_writer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // write-bus monitor
    logic [63:0] got_q[$];
    int          cyc = 0;
    int          last_hs = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_word = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus_if.mem_wvalid && bus_if.mem_wready) begin
            got_q.push_back({bus_if.mem_addr, bus_if.mem_wdata});
            last_hs <= cyc;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!reset && prev_stall &&
            (bus_if.mem_wvalid !== 1'b1 || {bus_if.mem_addr, bus_if.mem_wdata} !== prev_word))
            stab_err <= stab_err + 1;
        prev_stall <= bus_if.mem_wvalid && !bus_if.mem_wready;
        prev_word  <= {bus_if.mem_addr, bus_if.mem_wdata};
    end

    // frame-level reference model
    logic [63:0] exp_q[$];
    int          exp_done = 0;
    int          rd_idx = 0;
    bit          m_cap = 0;
    int          m_key = -1;
    logic [7:0]  m_lane [4];
    bit          rand_ready = 0;
    logic        ready_level = 1'b0;

    task automatic m_clear();
        for (int k = 0; k < 4; k++) m_lane[k] = 8'h00;
        m_key = -1;
    endtask

    task automatic model_pix(input logic [7:0] v, input int xx, input int yy, input bit vld);
        int key;
        if (!(vld && xx < W && yy < H)) return;
        if (!m_cap) begin
            if (xx == 0 && yy == 0 && enable) begin
                m_cap = 1;
                m_clear();
            end
        end else if (xx == 0 && yy == 0) begin
            m_clear();
        end
        if (m_cap) begin
            key = yy * 256 + xx / 4;
            if (key != m_key) begin
                m_clear();
                m_key = key;
            end
            m_lane[xx % 4] = v;
            if (xx % 4 == 3) begin
                exp_q.push_back({BASE + 32'(4 * ((yy * W + xx) / 4)),
                                 m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
                for (int k = 0; k < 4; k++) m_lane[k] = 8'h00;
            end
            if (xx == W - 1 && yy == H - 1) begin
                m_cap = 0;
                exp_done++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.mem_wready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
    endtask

    task automatic put(input logic [7:0] v, input int xx, input int yy, input bit vld);
        bus_if.value  = v;
        bus_if.x      = 10'(xx);
        bus_if.y      = 10'(yy);
        bus_if.is_val = vld;
        model_pix(v, xx, yy, vld);
        tick();
        bus_if.is_val = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_cnt < exp_done; i++) tick();
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, "_done_timing"}, 64'(done_cyc), 64'(last_hs + 1));
    endtask

    task automatic chk_words(input string tag);
        logic [63:0] g;
        chk({tag, "_nwords"}, 64'(got_q.size() - rd_idx), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (rd_idx + i < got_q.size()) ? got_q[rd_idx + i] : 'x;
            chk({tag, "_word"}, g, exp_q[i]);
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    task automatic rand_frame(input bit gaps);
        bit must;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                must = (xx == 0 && yy == 0) || (xx == W - 1 && yy == H - 1);
                if ($urandom_range(0, 7) == 0) put(8'($urandom), W + $urandom_range(0, 3), yy, 1);
                if ($urandom_range(0, 7) == 0) put(8'($urandom), xx, H, 1);
                if (!must && $urandom_range(0, 9) == 0) put(8'($urandom), 0, 0, 0);
                if (must || $urandom_range(0, 4) != 0) put(8'($urandom), xx, yy, 1);
                if (gaps && $urandom_range(0, 3) == 0) tick();
            end
        end
    endtask

    initial begin
        logic [63:0] head;
        reset             = 1'b1;
        enable            = 1'b0;
        bus_if.value      = '0;
        bus_if.x          = '0;
        bus_if.y          = '0;
        bus_if.is_val     = 1'b0;
        bus_if.mem_wready = 1'b0;
        m_clear();
        tick(); tick(); tick();
        chk("rst_wvalid", 64'(bus_if.mem_wvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_addr", 64'(bus_if.mem_addr), 64'd0);
        chk("rst_wdata", 64'(bus_if.mem_wdata), 64'd0);
        reset = 1'b0;
        tick();

        // indexed frame, always ready, with show-ahead latency probe
        ready_level = 1'b1;
        enable = 1'b1;
        tick();
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                put(8'(yy * W + xx), xx, yy, 1);
                if (yy == 0 && xx == 3) chk("lat_pre", 64'(bus_if.mem_wvalid), 64'd0);
                if (yy == 0 && xx == 4) begin
                    chk("lat_valid", 64'(bus_if.mem_wvalid), 64'd1);
                    chk("lat_word", {bus_if.mem_addr, bus_if.mem_wdata}, 64'h0000_1000_0302_0100);
                end
            end
        end
        wait_done("idx");
        head = (got_q.size() > rd_idx + 1) ? got_q[rd_idx + 1] : 'x;
        chk("idx_word1_const", head, 64'h0000_1004_0706_0504);
        chk_words("idx");
        chk("idx_ovf", 64'(overflow), 64'd0);
        chk("idx_busy", 64'(busy), 64'd0);

        // enable low at the origin: frame ignored
        enable = 1'b0;
        put(8'h55, 0, 0, 1);
        chk("dis_busy", 64'(busy), 64'd0);
        for (int xx = 1; xx < W; xx++) put(8'($urandom), xx, 0, 1);
        for (int yy = 1; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) put(8'($urandom), xx, yy, 1);
        tick(); tick();
        chk("dis_nwrites", 64'(got_q.size() - rd_idx), 64'd0);
        chk("dis_busy_end", 64'(busy), 64'd0);

        // armed at origin, enable dropped mid-frame does not abort
        enable = 1'b1;
        put(8'($urandom), 0, 0, 1);
        chk("en_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        for (int xx = 1; xx < W; xx++) put(8'($urandom), xx, 0, 1);
        for (int yy = 1; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) put(8'($urandom), xx, yy, 1);
        wait_done("en");
        chk_words("en");

        // restart at origin after x=0..5 of line 0
        enable = 1'b1;
        for (int xx = 0; xx < 6; xx++) put(8'(xx), xx, 0, 1);
        rand_frame(1'b0);
        wait_done("rst0");
        head = (got_q.size() > rd_idx) ? got_q[rd_idx] : 'x;
        chk("rst0_first_const", head, 64'h0000_1000_0302_0100);
        chk_words("rst0");

        // memory stalled for the whole frame
        ready_level = 1'b0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) put(8'($urandom), xx, yy, 1);
        tick(); tick();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        chk("ovf_nowrites", 64'(got_q.size() - rd_idx), 64'd0);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        ready_level = 1'b1;
        wait_done("ovf");
        chk_words("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // full FIFO with pop in the push cycle
        ready_level = 1'b0;
        put(8'($urandom), 0, 0, 1);
        chk("ovf_clear", 64'(overflow), 64'd0);
        for (int xx = 1; xx < W; xx++) put(8'($urandom), xx, 0, 1);
        for (int xx = 0; xx < W; xx++) put(8'($urandom), xx, 1, 1);
        for (int xx = 0; xx < 4; xx++) put(8'($urandom), xx, 2, 1);
        ready_level = 1'b1;
        bus_if.mem_wready = 1'b1;
        put(8'($urandom), 4, 2, 1);
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        for (int xx = 5; xx < W; xx++) put(8'($urandom), xx, 2, 1);
        wait_done("fullpop");
        chk_words("fullpop");
        chk("fullpop_ovf_end", 64'(overflow), 64'd0);

        // reset while draining three queued words
        ready_level = 1'b0;
        put(8'h11, 0, 0, 1);
        put(8'h22, 1, 0, 1);
        put(8'h33, 2, 0, 1);
        put(8'h44, 3, 0, 1);
        put(8'h55, 3, 1, 1);
        put(8'h66, W - 1, H - 1, 1);
        tick(); tick();
        chk("drn_busy", 64'(busy), 64'd1);
        chk("drn_wvalid", 64'(bus_if.mem_wvalid), 64'd1);
        reset = 1'b1;
        ready_level = 1'b1;
        bus_if.mem_wready = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_done--;
        m_cap = 0;
        m_clear();
        chk("drn_rst_wvalid", 64'(bus_if.mem_wvalid), 64'd0);
        chk("drn_rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("drn_rst_nowrites", 64'(got_q.size() - rd_idx), 64'd0);
        chk("drn_rst_nodone", 64'(done_cnt), 64'(exp_done));

        // randomized frames with skipped, out-of-range and invalid pixels
        rand_ready = 1;
        for (int f = 0; f < 3; f++) begin
            rand_frame(1'b1);
            wait_done("rnd");
            chk_words("rnd");
            chk("rnd_ovf", 64'(overflow), 64'd0);
        end

        chk("hold_stable", 64'(stab_err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per line; a multiple of 4.
REQ-002 SHALL have parameter IMG_H, default 240, lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of pixel (0,0).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, word FIFO entries; a power of 2.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock for all logic.
REQ-006 SHALL have: reset  in  1  synchronous active-high reset.
REQ-007 SHALL have: enable  in  1  arms capture of the next frame.
REQ-008 SHALL have: value  in  8  pixel intensity from the camera stage.
REQ-009 SHALL have: x  in  10  pixel column.
REQ-010 SHALL have: y  in  10  pixel row.
REQ-011 SHALL have: is_val  in  1  value/x/y valid this cycle.
REQ-012 SHALL have: mem_addr  out  32  byte address of the write word.
REQ-013 SHALL have: mem_wdata  out  32  four packed pixels.
REQ-014 SHALL have: mem_wvalid  out  1  write request.
REQ-015 SHALL have: mem_wready  in  1  memory accepts the word when high with mem_wvalid.
REQ-016 SHALL have: busy  out  1  high in CAPTURE or DRAIN.
REQ-017 SHALL have: frame_done  out  1  one-cycle completion pulse.
REQ-018 SHALL have: overflow  out  1  sticky: at least one word dropped this frame.

Function
REQ-019 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-020 IDLE->CAPTURE SHALL occur on is_val with x==0, y==0 and enable high; that pixel is captured.
REQ-021 CAPTURE->DRAIN SHALL occur on the accepted pixel x==IMG_W-1, y==IMG_H-1.
REQ-022 DRAIN->IDLE SHALL occur once the FIFO is empty with no word outstanding; frame_done pulses in the cycle after the last mem handshake.
REQ-023 enable SHALL be sampled only in IDLE; deassertion mid-frame does not abort.
REQ-024 Pixels with x>=IMG_W or y>=IMG_H, or is_val low, SHALL be ignored.
REQ-025 Pixel SHALL be placed in byte lane x[1:0] (lane 0 = bits 7:0).
REQ-026 A word SHALL be pushed in the cycle after a pixel with x[1:0]==3 is accepted.
REQ-027 Word address SHALL be BASE_ADDR + 4*((y*IMG_W + x)>>2), computed from x,y of the lane-3 pixel, 32-bit wraparound.
REQ-028 FIFO SHALL be show-ahead: mem_wvalid high the cycle after push into an empty FIFO (2-cycle latency from lane-3 pixel).
REQ-029 mem_addr/mem_wdata SHALL hold stable while mem_wvalid high and mem_wready low.
REQ-030 Push into a full FIFO SHALL drop the word and set overflow, unless a pop occurs in the same cycle, in which case push succeeds.
REQ-031 overflow SHALL clear on the IDLE->CAPTURE transition.
REQ-032 Pixel (0,0) arriving in CAPTURE SHALL restart the frame: partial pack discarded, queued FIFO words still drained.
REQ-033 Unwritten lanes of a word after a restart or dropped pixels SHALL be 0.

Reset
REQ-034 Reset SHALL force IDLE, empty FIFO, cleared pack register, and mem_wvalid=0, busy=0, frame_done=0, overflow=0, mem_addr=0, mem_wdata=0.
REQ-035 Reset mid-frame SHALL discard all queued words without further handshakes.

Structure
REQ-036 Package cam_pkg SHALL hold PIX_W=8, COORD_W=10, the state enum, and default IMG_W/IMG_H.
REQ-037 FIFO SHALL be sub-module sync_fifo (parameterised width/depth, full/empty, show-ahead).

Verification
REQ-038 4x2 frame, mem_wready=1, BASE_ADDR=0x1000: pixels 0..7 -> words 0x03020100@0x1000, 0x07060504@0x1004, frame_done once.
REQ-039 mem_wready=0 for whole 320x240 frame at 1 pixel/cycle -> exactly FIFO_DEPTH words retained, overflow=1, later drain writes them in order.
REQ-040 enable=0 at (0,0) -> no writes, busy=0; enable=1 next frame -> capture starts.
REQ-041 Restart at (0,0) after x=0..5 of line 0 -> word 0x03020100 written, partial lanes 4,5 discarded.
REQ-042 Reset asserted in DRAIN with 3 queued words -> mem_wvalid=0 next cycle, state IDLE, no frame_done.
REQ-043 Push while full with simultaneous pop -> word accepted, overflow stays 0.
